// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: glyph constants and
// the scanner state encoding. Glyph bits are active-high, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

   localparam logic [6:0] SEG_0 = 7'b0111111;
   localparam logic [6:0] SEG_1 = 7'b0000110;
   localparam logic [6:0] SEG_2 = 7'b1011011;
   localparam logic [6:0] SEG_3 = 7'b1001111;
   localparam logic [6:0] SEG_4 = 7'b1100110;
   localparam logic [6:0] SEG_5 = 7'b1101101;
   localparam logic [6:0] SEG_6 = 7'b1111101;
   localparam logic [6:0] SEG_7 = 7'b0000111;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1101111;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_B = 7'b1111100;
   localparam logic [6:0] SEG_C = 7'b0111001;
   localparam logic [6:0] SEG_D = 7'b1011110;
   localparam logic [6:0] SEG_E = 7'b1111001;
   localparam logic [6:0] SEG_F = 7'b1110001;

   // Scanner phases: all anodes dark, or one digit lit.
   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment glyph (0-F, lowercase b and d).
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   // Glyph lookup for the full hex range.
   always_comb begin
      seg = SEG_8;
      case (hex)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         4'hF:    seg = SEG_F;
         default: seg = SEG_8;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a common-anode seven-segment display.
// A new word is parked in a one-deep pending slot and only copied into the
// display register when the scan wraps back to digit 0, so a frame never
// mixes old and new digits. A blanking gap precedes every lit digit.
module seven_seg_scanner
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int SHOW_TICKS  = 90_000,
   parameter int BLANK_TICKS = 10_000
)
(
   input  logic                      CLK100MHZ,
   input  logic                      CPU_RESETN,
   input  logic [4*NUM_DIGITS-1:0]   data_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     digit_en,
   input  logic                      data_valid,
   output logic                      data_ready,
   output logic [NUM_DIGITS-1:0]     AN,
   output logic                      CA,
   output logic                      CB,
   output logic                      CC,
   output logic                      CD,
   output logic                      CE,
   output logic                      CF,
   output logic                      CG,
   output logic                      DP,
   output logic                      frame_start
);

   localparam int MAX_TICKS = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
   localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_TICKS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   scan_state_t               state_r;
   logic [CNT_W-1:0]          cnt_r;
   logic [IDX_W-1:0]          idx_r;
   logic [4*NUM_DIGITS-1:0]   display_r;
   logic [NUM_DIGITS-1:0]     dp_disp_r;
   logic [4*NUM_DIGITS-1:0]   pending_data_r;
   logic [NUM_DIGITS-1:0]     pending_dp_r;
   logic                      pending_full_r;
   logic                      data_ready_r;
   logic [NUM_DIGITS-1:0]     an_r;
   logic [6:0]                seg_n_r;
   logic                      dp_n_r;
   logic                      frame_start_r;

   logic [3:0]                nibble_s;
   logic [6:0]                glyph_s;
   logic                      dp_sel_s;
   logic [NUM_DIGITS-1:0]     an_show_s;
   logic                      accept_s;
   logic                      reload_s;
   logic                      pending_full_next_s;

   hex_to_seg u_hex_to_seg (
      .hex (nibble_s),
      .seg (glyph_s)
   );

   // Select the digit about to be lit and work out handshake/reload events.
   always_comb begin
      nibble_s            = display_r[{idx_r, 2'b00} +: 4];
      dp_sel_s            = dp_disp_r[idx_r];
      accept_s            = data_valid & data_ready_r;
      reload_s            = 1'b0;
      pending_full_next_s = pending_full_r;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_show_s[i] = ~(digit_en[i] & (idx_r == IDX_W'(i)));
      end
      if ((state_r == SHOW) && (cnt_r == SHOW_LAST) && (idx_r == IDX_LAST)) begin
         reload_s = pending_full_r;
      end else begin
         reload_s = 1'b0;
      end
      if (accept_s) begin
         pending_full_next_s = 1'b1;
      end else if (reload_s) begin
         pending_full_next_s = 1'b0;
      end else begin
         pending_full_next_s = pending_full_r;
      end
   end

   // Scan FSM with pending/display registers and registered pin drivers.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_r        <= BLANK;
         cnt_r          <= {CNT_W{1'b0}};
         idx_r          <= {IDX_W{1'b0}};
         display_r      <= {(4*NUM_DIGITS){1'b0}};
         dp_disp_r      <= {NUM_DIGITS{1'b0}};
         pending_data_r <= {(4*NUM_DIGITS){1'b0}};
         pending_dp_r   <= {NUM_DIGITS{1'b0}};
         pending_full_r <= 1'b0;
         data_ready_r   <= 1'b1;
         an_r           <= {NUM_DIGITS{1'b1}};
         seg_n_r        <= 7'h7F;
         dp_n_r         <= 1'b1;
         frame_start_r  <= 1'b0;
      end else begin
         frame_start_r  <= 1'b0;
         pending_full_r <= pending_full_next_s;
         data_ready_r   <= ~pending_full_next_s;
         if (accept_s) begin
            pending_data_r <= data_in;
            pending_dp_r   <= dp_in;
         end
         case (state_r)
            BLANK: begin
               if (cnt_r == BLANK_LAST) begin
                  state_r <= SHOW;
                  cnt_r   <= {CNT_W{1'b0}};
                  an_r    <= an_show_s;
                  seg_n_r <= ~glyph_s;
                  dp_n_r  <= ~dp_sel_s;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            SHOW: begin
               if (cnt_r == SHOW_LAST) begin
                  state_r <= BLANK;
                  cnt_r   <= {CNT_W{1'b0}};
                  an_r    <= {NUM_DIGITS{1'b1}};
                  seg_n_r <= 7'h7F;
                  dp_n_r  <= 1'b1;
                  if (idx_r == IDX_LAST) begin
                     idx_r <= {IDX_W{1'b0}};
                  end else begin
                     idx_r <= idx_r + 1'b1;
                  end
                  if (reload_s) begin
                     display_r     <= pending_data_r;
                     dp_disp_r     <= pending_dp_r;
                     frame_start_r <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            default: begin
               state_r <= BLANK;
               cnt_r   <= {CNT_W{1'b0}};
               an_r    <= {NUM_DIGITS{1'b1}};
               seg_n_r <= 7'h7F;
               dp_n_r  <= 1'b1;
            end
         endcase
      end
   end

   assign data_ready  = data_ready_r;
   assign AN          = an_r;
   assign CA          = seg_n_r[0];
   assign CB          = seg_n_r[1];
   assign CC          = seg_n_r[2];
   assign CD          = seg_n_r[3];
   assign CE          = seg_n_r[4];
   assign CF          = seg_n_r[5];
   assign CG          = seg_n_r[6];
   assign DP          = dp_n_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with short scan timing.
module tb_seven_seg_scanner;

   localparam int ND    = 8;
   localparam int ST    = 4;
   localparam int BT    = 2;
   localparam int SLOT  = BT + ST;
   localparam int FRAME = ND * SLOT;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      int          acc_cyc;
   } word_t;

   logic        CLK100MHZ = 1'b0;
   logic        CPU_RESETN;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic [7:0]  digit_en;
   logic        data_valid;
   logic        data_ready;
   logic [7:0]  AN;
   logic        CA, CB, CC, CD, CE, CF, CG, DP;
   logic        frame_start;
   logic [6:0]  seg_obs;

   int checks;
   int errors;
   int cyc;

   word_t tx_q[$];
   word_t sb_q[$];

   logic [7:0] obs_an  [FRAME];
   logic [6:0] obs_seg [FRAME];
   logic       obs_dp  [FRAME];
   logic       obs_fs  [FRAME];
   logic       obs_rdy [FRAME];

   assign seg_obs = {CA, CB, CC, CD, CE, CF, CG};

   seven_seg_scanner #(
      .NUM_DIGITS  (ND),
      .SHOW_TICKS  (ST),
      .BLANK_TICKS (BT)
   ) dut (
      .CLK100MHZ   (CLK100MHZ),
      .CPU_RESETN  (CPU_RESETN),
      .data_in     (data_in),
      .dp_in       (dp_in),
      .digit_en    (digit_en),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .AN          (AN),
      .CA          (CA),
      .CB          (CB),
      .CC          (CC),
      .CD          (CD),
      .CE          (CE),
      .CF          (CF),
      .CG          (CG),
      .DP          (DP),
      .frame_start (frame_start)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   // Active-low {CA..CG} patterns written from the segment lists.
   function automatic logic [6:0] glyph_n(input logic [3:0] h);
      case (h)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   function automatic logic [7:0] exp_an(input int off, input logic [7:0] en);
      int d;
      logic [7:0] oh;
      d  = off / SLOT;
      oh = 8'h01 << d;
      if ((off % SLOT) < BT || !en[d]) return 8'hFF;
      else return ~oh;
   endfunction

   function automatic logic [6:0] exp_seg(input int off, input logic [31:0] data);
      int d;
      d = off / SLOT;
      if ((off % SLOT) < BT) return 7'h7F;
      else return glyph_n(data[4*d +: 4]);
   endfunction

   function automatic logic exp_dp(input int off, input logic [7:0] dp);
      int d;
      d = off / SLOT;
      if ((off % SLOT) < BT) return 1'b1;
      else return ~dp[d];
   endfunction

   task automatic load_next();
      word_t w;
      if (tx_q.size() > 0) begin
         w          = tx_q.pop_front();
         data_in    = w.data;
         dp_in      = w.dp;
         data_valid = 1'b1;
      end else begin
         data_valid = 1'b0;
      end
   endtask

   task automatic send(input logic [31:0] d, input logic [7:0] p);
      word_t w;
      w.data = d;
      w.dp = p;
      w.acc_cyc = 0;
      tx_q.push_back(w);
      if (!data_valid) load_next();
   endtask

   // Advance one cycle; a word offered with ready high is pushed to the scoreboard.
   task automatic step();
      logic acc;
      word_t w;
      acc = data_valid & data_ready & CPU_RESETN;
      @(negedge CLK100MHZ);
      cyc++;
      if (acc) begin
         w.data = data_in;
         w.dp = dp_in;
         w.acc_cyc = cyc;
         sb_q.push_back(w);
         load_next();
      end
   endtask

   task automatic do_reset(input logic [7:0] en);
      CPU_RESETN = 1'b0;
      data_valid = 1'b0;
      digit_en   = en;
      tx_q.delete();
      sb_q.delete();
      repeat (3) @(negedge CLK100MHZ);
      CPU_RESETN = 1'b1;
      cyc = 0;
   endtask

   task automatic observe_frame();
      for (int t = 0; t < FRAME; t++) begin
         obs_an[t]  = AN;
         obs_seg[t] = seg_obs;
         obs_dp[t]  = DP;
         obs_fs[t]  = frame_start;
         obs_rdy[t] = data_ready;
         step();
      end
   endtask

   task automatic run_to_frame_edge();
      while ((cyc % FRAME) != 0) step();
   endtask

   task automatic test_reset();
      logic [7:0] an_tab [9];
      an_tab = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFD};
      digit_en   = 8'hFF;
      data_valid = 1'b0;
      #1 CPU_RESETN = 1'b0;
      repeat (2) @(negedge CLK100MHZ);
      checks++;
      if (AN !== 8'hFF || seg_obs !== 7'h7F || DP !== 1'b1) begin
         errors++;
         $display("FAIL reset_pins: AN=%h seg=%b DP=%b, want FF 1111111 1", AN, seg_obs, DP);
      end
      checks++;
      if (frame_start !== 1'b0 || data_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_hs: frame_start=%b ready=%b, want 0 1", frame_start, data_ready);
      end
      CPU_RESETN = 1'b1;
      cyc = 0;
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (AN !== an_tab[i]) begin
            errors++;
            $display("FAIL reset_timing cyc %0d: AN=%h, want %h", i, AN, an_tab[i]);
         end
         step();
      end
   endtask

   task automatic test_scan_zero();
      do_reset(8'hFF);
      observe_frame();
      for (int t = 0; t < FRAME; t++) begin
         checks++;
         if (obs_an[t] !== exp_an(t, 8'hFF) || obs_seg[t] !== exp_seg(t, 32'h0) ||
             obs_dp[t] !== exp_dp(t, 8'h00) || obs_fs[t] !== 1'b0) begin
            errors++;
            $display("FAIL scan_zero t=%0d: AN=%h seg=%b DP=%b fs=%b, want %h %b %b 0", t,
                     obs_an[t], obs_seg[t], obs_dp[t], obs_fs[t],
                     exp_an(t, 8'hFF), exp_seg(t, 32'h0), exp_dp(t, 8'h00));
         end
      end
      checks++;
      if (frame_start !== 1'b0 || AN !== 8'hFF) begin
         errors++;
         $display("FAIL scan_wrap_idle: fs=%b AN=%h, want 0 FF", frame_start, AN);
      end
      step();
      step();
      checks++;
      if (AN !== 8'hFE) begin
         errors++;
         $display("FAIL scan_wrap_fe: AN=%h, want FE", AN);
      end
   endtask

   task automatic test_load();
      word_t w;
      int pulses;
      do_reset(8'hFF);
      send(32'h0000_000F, 8'h01);
      step();
      checks++;
      if (data_ready !== 1'b0 || sb_q.size() != 1) begin
         errors++;
         $display("FAIL load_accept: ready=%b sb=%0d, want 0 1", data_ready, sb_q.size());
      end
      run_to_frame_edge();
      checks++;
      if (frame_start !== 1'b1 || data_ready !== 1'b1) begin
         errors++;
         $display("FAIL load_boundary: fs=%b ready=%b, want 1 1", frame_start, data_ready);
      end
      if (sb_q.size() > 0) w = sb_q.pop_front();
      else begin w.data = 32'h0; w.dp = 8'h00; end
      observe_frame();
      pulses = 0;
      for (int t = 0; t < FRAME; t++) begin
         if (obs_fs[t] === 1'b1) pulses++;
         checks++;
         if (obs_an[t] !== exp_an(t, 8'hFF) || obs_seg[t] !== exp_seg(t, 32'h0000_000F) ||
             obs_dp[t] !== exp_dp(t, 8'h01)) begin
            errors++;
            $display("FAIL load_frame t=%0d: AN=%h seg=%b DP=%b, want %h %b %b", t,
                     obs_an[t], obs_seg[t], obs_dp[t],
                     exp_an(t, 8'hFF), exp_seg(t, 32'h0000_000F), exp_dp(t, 8'h01));
         end
      end
      checks++;
      if (pulses != 1 || w.data !== 32'h0000_000F || w.dp !== 8'h01) begin
         errors++;
         $display("FAIL load_pulse: pulses=%0d word=%h/%h, want 1 0000000f/01", pulses, w.data, w.dp);
      end
   endtask

   task automatic test_back_to_back(input logic [31:0] a, input logic [7:0] ap,
                                    input logic [31:0] b, input logic [7:0] bp);
      word_t w;
      logic hold_bad;
      logic [31:0] xd;
      logic [7:0]  xp;
      do_reset(8'hFF);
      send(a, ap);
      send(b, bp);
      step();
      checks++;
      if (data_ready !== 1'b0 || data_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: ready=%b valid=%b, want 0 1", data_ready, data_valid);
      end
      hold_bad = 1'b0;
      while ((cyc % FRAME) != 0) begin
         if (data_ready !== 1'b0) hold_bad = 1'b1;
         step();
      end
      checks++;
      if (hold_bad) begin
         errors++;
         $display("FAIL b2b_hold: ready rose before the boundary, want 0 throughout");
      end
      for (int k = 0; k < 2; k++) begin
         xd = (k == 0) ? a : b;
         xp = (k == 0) ? ap : bp;
         run_to_frame_edge();
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_sb frame %0d: scoreboard empty, want word %h", k, xd);
            w.data = 32'h0;
            w.dp = 8'h00;
         end else begin
            w = sb_q.pop_front();
            if (w.data !== xd || w.dp !== xp) begin
               errors++;
               $display("FAIL b2b_order frame %0d: word %h/%h, want %h/%h", k, w.data, w.dp, xd, xp);
            end
         end
         observe_frame();
         for (int t = 0; t < FRAME; t++) begin
            checks++;
            if (obs_an[t] !== exp_an(t, 8'hFF) || obs_seg[t] !== exp_seg(t, w.data) ||
                obs_dp[t] !== exp_dp(t, w.dp) || obs_fs[t] !== (t == 0)) begin
               errors++;
               $display("FAIL b2b_frame %0d t=%0d: AN=%h seg=%b DP=%b fs=%b, want %h %b %b %b",
                        k, t, obs_an[t], obs_seg[t], obs_dp[t], obs_fs[t],
                        exp_an(t, 8'hFF), exp_seg(t, w.data), exp_dp(t, w.dp), (t == 0));
            end
         end
         checks++;
         if (obs_rdy[0] !== 1'b1 || obs_rdy[1] !== (k == 1)) begin
            errors++;
            $display("FAIL b2b_ready frame %0d: ready=%b,%b, want 1,%b", k, obs_rdy[0], obs_rdy[1], (k == 1));
         end
      end
      checks++;
      if (sb_q.size() != 0 || data_ready !== 1'b1 || frame_start !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: sb=%0d ready=%b fs=%b, want 0 1 0", sb_q.size(), data_ready, frame_start);
      end
   endtask

   task automatic test_digit_en();
      do_reset(8'h01);
      for (int f = 0; f < 2; f++) begin
         observe_frame();
         for (int t = 0; t < FRAME; t++) begin
            checks++;
            if ((obs_an[t] !== 8'hFE && obs_an[t] !== 8'hFF) || obs_an[t] !== exp_an(t, 8'h01)) begin
               errors++;
               $display("FAIL digit_en frame %0d t=%0d: AN=%h, want %h", f, t, obs_an[t], exp_an(t, 8'h01));
            end
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      do_reset(8'hFF);
      send(32'h1234_5678, 8'hFF);
      step();
      while (cyc < 21) step();
      checks++;
      if (AN !== 8'hF7 || data_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_pre: AN=%h ready=%b, want F7 0", AN, data_ready);
      end
      #2 CPU_RESETN = 1'b0;
      #1;
      checks++;
      if (AN !== 8'hFF || seg_obs !== 7'h7F || DP !== 1'b1 || data_ready !== 1'b1 || frame_start !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: AN=%h seg=%b DP=%b ready=%b fs=%b, want FF 1111111 1 1 0",
                  AN, seg_obs, DP, data_ready, frame_start);
      end
      @(negedge CLK100MHZ);
      tx_q.delete();
      sb_q.delete();
      CPU_RESETN = 1'b1;
      cyc = 0;
      for (int f = 0; f < 2; f++) begin
         observe_frame();
         for (int t = 0; t < FRAME; t++) begin
            checks++;
            if (obs_an[t] !== exp_an(t, 8'hFF) || obs_seg[t] !== exp_seg(t, 32'h0) ||
                obs_dp[t] !== exp_dp(t, 8'h00) || obs_fs[t] !== 1'b0) begin
               errors++;
               $display("FAIL mid_after frame %0d t=%0d: AN=%h seg=%b DP=%b fs=%b, want %h %b %b 0",
                        f, t, obs_an[t], obs_seg[t], obs_dp[t], obs_fs[t],
                        exp_an(t, 8'hFF), exp_seg(t, 32'h0), exp_dp(t, 8'h00));
            end
         end
      end
   endtask

   initial begin
      CPU_RESETN = 1'b1;
      data_in    = 32'h0;
      dp_in      = 8'h00;
      digit_en   = 8'hFF;
      data_valid = 1'b0;
      checks     = 0;
      errors     = 0;
      cyc        = 0;
      test_reset();
      test_scan_zero();
      test_load();
      test_back_to_back(32'h0000_0001, 8'h00, 32'h0000_0002, 8'h00);
      test_back_to_back(32'h7654_3210, 8'hA5, 32'hFEDC_BA98, 8'h5A);
      test_digit_en();
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200_000;
      $display("FAIL timeout: simulation still running at %0t, want finished", $time);
      $fatal(1, "timeout");
   end

endmodule
